mem_loader: RTL and testbench
=============================

# mem_loader

Synthesizable main-memory bootstrap and write-port arbiter for the LSTM accelerator. It accepts a stream of `ELEMENT_BITS` words, writes them into the W1, W2 and input regions of main memory in a fixed order, waits a programmable settle delay, then raises `start` and hands the main-memory write port to the DMAC. It replaces hand-sequenced memory preloading with a parametrised, restartable loader that also supports an inputs-only reload.

## Interface
- `ELEMENT_BITS`, 8, data word width
- `MAIN_MEM_ADD_LEN`, 11, main-memory address width
- `WEIGHTS`, 64, words per weight region (W1 and W2 each)
- `FEATURES`, 4, input features per cycle
- `CYCLES`, 10, input time steps; INPUT_SIZE = FEATURES*CYCLES
- `START_DELAY`, 50, idle cycles between last write and `start`; 0 legal
- Derived layout: IN_FIRST=0, W1_FIRST=INPUT_SIZE, W2_FIRST=W1_FIRST+WEIGHTS, OUT_FIRST=W2_FIRST+WEIGHTS; elaboration error if OUT_FIRST >= 2^MAIN_MEM_ADD_LEN

- `fpga_clk` in 1, sole clock, rising edge
- `reset` in 1, synchronous, active-high
- `load_go` in 1, pulse; starts a load session, sampled only in IDLE
- `load_mode` in 1, sampled with `load_go`: 0 = full (W1, W2, IN), 1 = inputs only (IN)
- `load_valid` in 1, stream word valid
- `load_ready` out 1, loader accepts word
- `load_data` in ELEMENT_BITS, stream word
- `dmac_we` / `dmac_address` / `dmac_data` in 1 / MAIN_MEM_ADD_LEN / ELEMENT_BITS, DMAC write port
- `mem_we` / `mem_address` / `mem_data` out 1 / MAIN_MEM_ADD_LEN / ELEMENT_BITS, main-memory write port
- `start` out 1, level; accelerator run enable
- `busy` out 1, high in LOAD_W1, LOAD_W2, LOAD_IN, WAIT
- `load_done` out 1, one-cycle pulse on first RUN cycle
- `out_first` out MAIN_MEM_ADD_LEN, constant OUT_FIRST for the CPU

## Operation
- States: IDLE, LOAD_W1, LOAD_W2, LOAD_IN, WAIT, RUN.
- IDLE: `load_go` -> LOAD_W1 (mode 0) or LOAD_IN (mode 1); word counter cleared.
- LOAD_*: `load_ready`=1; beat = `load_valid && load_ready`; each beat writes `load_data` to region_base + counter, counter increments.
- Region-last beat (counter = WEIGHTS-1 in W1/W2, INPUT_SIZE-1 in IN): counter clears; W1->W2, W2->IN, IN->WAIT.
- WAIT: `load_ready`=0, `mem_we`=0; delay counter runs START_DELAY+1 cycles, then RUN.
- RUN: `start`=1, `mem_*` = `dmac_*` combinationally; `load_ready`=0; held until `reset`. `load_go` ignored outside IDLE.
- Outside RUN, `dmac_*` is ignored entirely.
- Reset anywhere: IDLE, counters 0, all outputs 0 (`out_first` constant); memory contents untouched, partial load abandoned.

## Timing
- Loader write path registered: beat in cycle N -> `mem_we`=1, `mem_address`, `mem_data` valid in cycle N+1; `mem_we`=0 in cycles after no beat.
- `load_ready` is state-decoded (no dependence on `load_valid`); back-to-back beats sustain one write per cycle, including across region boundaries.
- Last beat at cycle N: final write at N+1 (WAIT entry), `start` and `load_done` rise at N+2+START_DELAY.
- Reset values: `load_ready`, `mem_we`, `mem_address`, `mem_data`, `start`, `busy`, `load_done` all 0.
- RUN pass-through has zero latency; the last loader write never overlaps DMAC traffic.

## Test plan
- Full load, defaults, continuous valid, 168 beats: beat 1 -> addr 40, beat 64 -> addr 103, beat 65 -> addr 104, beat 129 -> addr 0, beat 168 -> addr 39; `start` rises 52 cycles after beat 168, `load_done` single pulse.
- Inputs-only (`load_mode`=1), 40 beats of 0x36..: addrs 0..39 written in order, W1/W2 addresses never driven, `start` as above.
- Backpressure gaps: `load_valid` toggling 1-0-0-1: exactly one `mem_we` per beat, addresses contiguous, no write on gap cycles.
- `reset` asserted at beat 70 (LOAD_W2): next cycle all outputs 0, state IDLE; new `load_go` restarts at addr 40.
- RUN pass-through: `dmac_we`=1, addr 200, data 0x5A -> same-cycle `mem_*` match; `load_go` and `load_valid` in RUN cause no writes.
- START_DELAY=0 build: last beat cycle N -> write at N+1, `start` at N+2.

Source files
------------

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Main-memory bootstrap loader and write-port arbiter for the LSTM
// accelerator. A session started by load_go streams ELEMENT_BITS words into
// main memory. A full session (load_mode=0) loads the W1, W2 and IN regions
// in that order. An inputs-only session (load_mode=1) loads just IN. After
// the last write the loader waits START_DELAY+1 cycles, then raises start
// and hands the memory write port to the DMAC until reset.
//
// Memory layout (word addresses):
//   IN_FIRST  = 0
//   W1_FIRST  = INPUT_SIZE
//   W2_FIRST  = W1_FIRST + WEIGHTS
//   OUT_FIRST = W2_FIRST + WEIGHTS (reported on out_first)
//
// Ports:
//   fpga_clk      in   sole clock, rising edge
//   reset         in   synchronous, active-high
//   load_go       in   session start pulse, sampled only in IDLE
//   load_mode     in   0 = full load, 1 = inputs only (sampled with load_go)
//   load_valid    in   stream word valid
//   load_ready    out  loader accepts a word (state-decoded)
//   load_data     in   stream word
//   dmac_*        in   DMAC write port, only honoured in RUN
//   mem_*         out  main-memory write port
//   start         out  accelerator run enable (level, RUN)
//   busy          out  high while loading or waiting
//   load_done     out  one-cycle pulse on the first RUN cycle
//   out_first     out  constant OUT_FIRST
//   dbg_state     out  current FSM state, for observation only
//
// Handshake: a word transfers on every rising edge where load_valid and
// load_ready are both high. load_ready never depends on load_valid, and the
// producer must hold load_data stable while load_valid is high.
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter int ELEMENT_BITS     = 8,
    parameter int MAIN_MEM_ADD_LEN = 11,
    parameter int WEIGHTS          = 64,
    parameter int FEATURES         = 4,
    parameter int CYCLES           = 10,
    parameter int START_DELAY      = 50
) (
    input  logic                        fpga_clk,
    input  logic                        reset,
    input  logic                        load_go,
    input  logic                        load_mode,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [ELEMENT_BITS-1:0]     load_data,
    input  logic                        dmac_we,
    input  logic [MAIN_MEM_ADD_LEN-1:0] dmac_address,
    input  logic [ELEMENT_BITS-1:0]     dmac_data,
    output logic                        mem_we,
    output logic [MAIN_MEM_ADD_LEN-1:0] mem_address,
    output logic [ELEMENT_BITS-1:0]     mem_data,
    output logic                        start,
    output logic                        busy,
    output logic                        load_done,
    output logic [MAIN_MEM_ADD_LEN-1:0] out_first,
    output logic [2:0]                  dbg_state
);

    localparam int AW         = MAIN_MEM_ADD_LEN;
    localparam int INPUT_SIZE = FEATURES * CYCLES;
    localparam int IN_FIRST   = 0;
    localparam int W1_FIRST   = INPUT_SIZE;
    localparam int W2_FIRST   = W1_FIRST + WEIGHTS;
    localparam int OUT_FIRST  = W2_FIRST + WEIGHTS;
    localparam int MAX_REGION = (WEIGHTS > INPUT_SIZE) ? WEIGHTS : INPUT_SIZE;
    localparam int CW         = $clog2(MAX_REGION + 1);
    localparam int DW         = $clog2(START_DELAY + 2);

    // The output region must start inside the addressable memory.
    generate
        if (OUT_FIRST >= (2 ** MAIN_MEM_ADD_LEN)) begin : g_layout_check
            $error("mem_loader: OUT_FIRST does not fit in MAIN_MEM_ADD_LEN address bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W1 = 3'd1,
        S_LOAD_W2 = 3'd2,
        S_LOAD_IN = 3'd3,
        S_WAIT    = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          dly_q, dly_d;
    logic                   wr_we_q, wr_we_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [ELEMENT_BITS-1:0] wr_data_q, wr_data_d;
    logic                   done_q, done_d;

    logic                   beat;
    logic [AW-1:0]          region_base;
    logic [CW-1:0]          region_last;
    state_t                 region_next;

    // Ready is purely a function of state so that the producer sees a
    // stable acceptance signal for the whole cycle.
    assign load_ready = (state_q == S_LOAD_W1) || (state_q == S_LOAD_W2) ||
                        (state_q == S_LOAD_IN);
    assign beat       = load_valid && load_ready;

    // Per-region base address, last counter value and successor state.
    always_comb begin
        region_base = AW'(IN_FIRST);
        region_last = CW'(INPUT_SIZE - 1);
        region_next = S_WAIT;
        case (state_q)
            S_LOAD_W1: begin
                region_base = AW'(W1_FIRST);
                region_last = CW'(WEIGHTS - 1);
                region_next = S_LOAD_W2;
            end
            S_LOAD_W2: begin
                region_base = AW'(W2_FIRST);
                region_last = CW'(WEIGHTS - 1);
                region_next = S_LOAD_IN;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        wr_we_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_go) begin
                    cnt_d   = '0;
                    state_d = load_mode ? S_LOAD_IN : S_LOAD_W1;
                end
            end
            S_LOAD_W1, S_LOAD_W2, S_LOAD_IN: begin
                if (beat) begin
                    wr_we_d   = 1'b1;
                    wr_addr_d = region_base + AW'(cnt_q);
                    wr_data_d = load_data;
                    if (cnt_q == region_last) begin
                        cnt_d   = '0;
                        dly_d   = '0;
                        state_d = region_next;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                // The final loader write is still on the port in the first
                // WAIT cycle; the count covers START_DELAY+1 cycles in total.
                if (dly_q == DW'(START_DELAY)) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            S_RUN: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dly_q     <= '0;
            wr_we_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            wr_we_q   <= wr_we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // In RUN the DMAC owns the port with zero latency; elsewhere the
    // registered loader write drives it and DMAC inputs are ignored.
    always_comb begin
        if (state_q == S_RUN) begin
            mem_we      = dmac_we;
            mem_address = dmac_address;
            mem_data    = dmac_data;
        end else begin
            mem_we      = wr_we_q;
            mem_address = wr_addr_q;
            mem_data    = wr_data_q;
        end
    end

    assign start     = (state_q == S_RUN);
    assign busy      = load_ready || (state_q == S_WAIT);
    assign load_done = done_q;
    assign out_first = AW'(OUT_FIRST);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  localparam int EB         = 8;
  localparam int AW         = 11;
  localparam int WEIGHTS    = 64;
  localparam int FEATURES   = 4;
  localparam int CYCLES     = 10;
  localparam int SD         = 50;
  localparam int INPUT_SIZE = FEATURES * CYCLES;
  localparam int W1_FIRST   = INPUT_SIZE;
  localparam int W2_FIRST   = W1_FIRST + WEIGHTS;
  localparam int OUT_FIRST  = W2_FIRST + WEIGHTS;
  localparam int FULL_BEATS = 2 * WEIGHTS + INPUT_SIZE;
  localparam int QW         = 32 + AW + EB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset = 1'b1;
  logic          load_go = 1'b0;
  logic          load_mode = 1'b0;
  logic          load_valid = 1'b0;
  logic [EB-1:0] load_data = '0;
  logic          dmac_we = 1'b0;
  logic [AW-1:0] dmac_address = '0;
  logic [EB-1:0] dmac_data = '0;
  logic          dmac0_we = 1'b0;
  logic [AW-1:0] dmac0_address = '0;
  logic [EB-1:0] dmac0_data = '0;

  logic          rdy, we, st, bsy, dn;
  logic [AW-1:0] addr, ofirst;
  logic [EB-1:0] data;
  logic [2:0]    dbg;
  logic          rdy0, we0, st0, bsy0, dn0;
  logic [AW-1:0] addr0, ofirst0;
  logic [EB-1:0] data0;
  logic [2:0]    dbg0;

  mem_loader #(.ELEMENT_BITS(EB), .MAIN_MEM_ADD_LEN(AW), .WEIGHTS(WEIGHTS),
               .FEATURES(FEATURES), .CYCLES(CYCLES), .START_DELAY(SD)) u_dut (
    .fpga_clk(clk), .reset(reset), .load_go(load_go), .load_mode(load_mode),
    .load_valid(load_valid), .load_ready(rdy), .load_data(load_data),
    .dmac_we(dmac_we), .dmac_address(dmac_address), .dmac_data(dmac_data),
    .mem_we(we), .mem_address(addr), .mem_data(data), .start(st), .busy(bsy),
    .load_done(dn), .out_first(ofirst), .dbg_state(dbg));

  mem_loader #(.ELEMENT_BITS(EB), .MAIN_MEM_ADD_LEN(AW), .WEIGHTS(WEIGHTS),
               .FEATURES(FEATURES), .CYCLES(CYCLES), .START_DELAY(0)) u_dut0 (
    .fpga_clk(clk), .reset(reset), .load_go(load_go), .load_mode(load_mode),
    .load_valid(load_valid), .load_ready(rdy0), .load_data(load_data),
    .dmac_we(dmac0_we), .dmac_address(dmac0_address), .dmac_data(dmac0_data),
    .mem_we(we0), .mem_address(addr0), .mem_data(data0), .start(st0), .busy(bsy0),
    .load_done(dn0), .out_first(ofirst0), .dbg_state(dbg0));

  // ---------------- scoreboard state ----------------
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] exp0_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_start  = -1;
  int exp_start0 = -1;
  int start_cnt  = 0;
  int start0_cnt = 0;
  bit run_phase  = 1'b0;
  logic prev_st = 1'b0;
  logic prev_st0 = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference order of addresses: W1 region, W2 region, then inputs.
  function automatic int ref_addr(input bit mode, input int k);
    if (mode) return k;
    if (k < WEIGHTS) return W1_FIRST + k;
    if (k < 2 * WEIGHTS) return W2_FIRST + (k - WEIGHTS);
    return k - 2 * WEIGHTS;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (we && !run_phase) begin
      check("dut_write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dut_write_cycle", cyc, e[QW-1 -: 32]);
        check("dut_write_addr", addr, e[AW+EB-1 -: AW]);
        check("dut_write_data", data, e[EB-1:0]);
      end
    end
    if (st && !prev_st) begin
      check("dut_start_cycle", cyc, exp_start);
      check("dut_load_done_at_start", dn, 1);
      start_cnt <= start_cnt + 1;
    end else if (dn) begin
      check("dut_load_done_extra", dn, 0);
    end
    prev_st <= st;
  end

  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (we0) begin
      check("dut0_write_expected", exp0_q.size() > 0, 1);
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        check("dut0_write_cycle", cyc, e[QW-1 -: 32]);
        check("dut0_write_addr", addr0, e[AW+EB-1 -: AW]);
        check("dut0_write_data", data0, e[EB-1:0]);
      end
    end
    if (st0 && !prev_st0) begin
      check("dut0_start_cycle", cyc, exp_start0);
      check("dut0_load_done_at_start", dn0, 1);
      start0_cnt <= start0_cnt + 1;
    end else if (dn0) begin
      check("dut0_load_done_extra", dn0, 0);
    end
    prev_st0 <= st0;
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, rdy, 0);     check({tag, "_ready0"}, rdy0, 0);
    check({tag, "_mem_we"}, we, 0);     check({tag, "_mem_we0"}, we0, 0);
    check({tag, "_mem_addr"}, addr, 0); check({tag, "_mem_addr0"}, addr0, 0);
    check({tag, "_mem_data"}, data, 0); check({tag, "_mem_data0"}, data0, 0);
    check({tag, "_start"}, st, 0);      check({tag, "_start0"}, st0, 0);
    check({tag, "_busy"}, bsy, 0);      check({tag, "_busy0"}, bsy0, 0);
    check({tag, "_done"}, dn, 0);       check({tag, "_done0"}, dn0, 0);
    check({tag, "_state"}, dbg, 0);     check({tag, "_state0"}, dbg0, 0);
  endtask

  task automatic do_reset(input int n);
    exp_start  = -1;
    exp_start0 = -1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one load session. abort_at (1-based beat) asserts reset on that beat.
  task automatic load_session(input bit mode, input int nb, input int gap_pct,
                              input int abort_at);
    int k;
    int last_cyc;
    logic [EB-1:0] d;
    load_go = 1'b1;
    load_mode = mode;
    @(posedge clk); #1;
    load_go = 1'b0;
    k = 0;
    last_cyc = -1;
    while (k < nb) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        load_valid = 1'b0;
      end else begin
        d = mode ? EB'(8'h36 + k) : EB'($urandom_range(255));
        load_valid = 1'b1;
        load_data  = d;
        if (abort_at == k + 1) begin
          reset = 1'b1;
        end else begin
          check("load_ready", rdy, 1);
          check("busy_loading", bsy, 1);
          exp_q.push_back({32'(cyc + 1), AW'(ref_addr(mode, k)), d});
          exp0_q.push_back({32'(cyc + 1), AW'(ref_addr(mode, k)), d});
          last_cyc = cyc;
        end
        k++;
      end
      @(posedge clk); #1;
      if (abort_at != 0 && abort_at == k) begin
        reset = 1'b0;
        load_valid = 1'b0;
        check_idle_outputs("after_abort");
        check("abort_queue_drained", exp_q.size(), 0);
        return;
      end
    end
    load_valid = 1'b0;
    exp_start  = last_cyc + 2 + SD;
    exp_start0 = last_cyc + 2;
  endtask

  task automatic wait_start(input int s_snap, input int s0_snap);
    for (int i = 0; i < 200; i++) begin
      if (start_cnt > s_snap && start0_cnt > s0_snap) break;
      @(posedge clk); #1;
    end
    check("start_seen", start_cnt > s_snap, 1);
    check("start0_seen", start0_cnt > s0_snap, 1);
    check("queue_empty", exp_q.size(), 0);
    check("queue0_empty", exp0_q.size(), 0);
    check("busy_in_run", bsy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, s0;
    logic          w;
    logic [AW-1:0] a;
    logic [EB-1:0] dd;

    do_reset(3);
    check_idle_outputs("reset");
    check("out_first", ofirst, OUT_FIRST);
    check("out_first0", ofirst0, OUT_FIRST);

    // Full load, continuous valid.
    s = start_cnt; s0 = start0_cnt;
    load_session(1'b0, FULL_BEATS, 0, 0);
    wait_start(s, s0);

    // RUN pass-through: zero-latency DMAC ownership.
    run_phase = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w  = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      a  = (i == 0) ? AW'(200) : AW'($urandom_range(2047));
      dd = (i == 0) ? EB'(8'h5A) : EB'($urandom_range(255));
      dmac_we = w; dmac_address = a; dmac_data = dd;
      #1;
      check("pass_we", we, w);
      check("pass_addr", addr, a);
      check("pass_data", data, dd);
      @(posedge clk); #1;
    end
    dmac_we = 1'b0;
    run_phase = 1'b0;
    load_go = 1'b1; load_valid = 1'b1;
    repeat (3) begin
      check("run_ready_low", rdy, 0);
      @(posedge clk); #1;
    end
    load_go = 1'b0; load_valid = 1'b0;
    check("run_start_held", st, 1);

    // Inputs-only reload.
    do_reset(1);
    s = start_cnt; s0 = start0_cnt;
    load_session(1'b1, INPUT_SIZE, 0, 0);
    wait_start(s, s0);

    // Full load with random backpressure gaps.
    do_reset(1);
    s = start_cnt; s0 = start0_cnt;
    load_session(1'b0, FULL_BEATS, 45, 0);
    wait_start(s, s0);

    // Reset on beat 70 (inside W2), then a fresh full load.
    do_reset(1);
    load_session(1'b0, FULL_BEATS, 0, 70);
    s = start_cnt; s0 = start0_cnt;
    load_session(1'b0, FULL_BEATS, 30, 0);
    wait_start(s, s0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
